// File: rtl/uart_rx_fifo_feeder_if.sv
// FIFO write-side bundle between the UART receiver and the board FIFO.
// Members: dout (byte to FIFO din), wen (write strobe), wfull (FIFO full).
interface uart_rx_fifo_feeder_if #(
   parameter int DW = 8
);
   logic [DW-1:0] dout;
   logic          wen;
   logic          wfull;

   modport master (
      output dout,
      output wen,
      input  wfull
   );

   modport slave (
      input  dout,
      input  wen,
      output wfull
   );
endinterface

// File: rtl/uart_rx_fifo_feeder.sv
// UART receiver (8N1, or 8E1 with `UART_RX_PARITY_EN) that writes each good
// byte straight into a synchronous FIFO, dropping it with overrun when full.
// Ports: clk, rst (sync, active-high), rx (async line, idles high),
//   fifo (master: dout/wen out, wfull in), busy, frame_err, overrun,
//   parity_err (one-cycle registered pulses; parity_err is 0 unless
//   UART_RX_PARITY_EN is defined).
module uart_rx_fifo_feeder #(
   parameter int DW     = 8,
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx,
   uart_rx_fifo_feeder_if.master fifo,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  parity_err
);
   localparam int CPB = CLK_HZ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam int BW  = $clog2(DW) + 1;

   localparam logic [CW-1:0] LAST  = CW'(CPB - 1);
   localparam logic [CW-1:0] MID   = CW'(CPB / 2 - 1);
   localparam logic [BW-1:0] BLAST = BW'(DW - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state_q, state_d;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          wen_q, wen_d;
   logic          fe_q, fe_d;
   logic          ov_q, ov_d;
   logic          tick;
`ifdef UART_RX_PARITY_EN
   logic          par_q, par_d;
   logic          pe_q, pe_d;
   logic          perr;

   // Even parity: the parity bit equals the XOR of the data bits.
   assign perr       = par_q ^ (^shift_q);
   assign parity_err = pe_q;
`else
   assign parity_err = 1'b0;
`endif

   assign tick      = (cnt_q == LAST);
   assign busy      = (state_q != IDLE);
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign fifo.dout = dout_q;
   assign fifo.wen  = wen_q;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      wen_d   = 1'b0;
      fe_d    = 1'b0;
      ov_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      pe_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (!rx_s) state_d = START;
         end
         START: begin
            // Still low at mid start bit: real frame, else a glitch.
            if (cnt_q == MID) begin
               state_d = rx_s ? IDLE : DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {rx_s, shift_q[DW-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BLAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               par_d   = rx_s;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            // Leaving at mid stop bit gives half a bit to catch
            // a back-to-back start edge.
            if (tick) begin
               state_d = IDLE;
               if (!rx_s) begin
                  fe_d    = 1'b1;
                  state_d = WAIT_HIGH;
               end
`ifdef UART_RX_PARITY_EN
               else if (perr) begin
                  pe_d = 1'b1;
               end
`endif
               else if (fifo.wfull) begin
                  ov_d = 1'b1;
               end else begin
                  wen_d  = 1'b1;
                  dout_d = shift_q;
               end
            end
         end
         WAIT_HIGH: begin
            // A held-low break must not look like new start bits.
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q || tick) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         wen_q   <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         pe_q    <= 1'b0;
`endif
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         wen_q   <= wen_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         pe_q    <= pe_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed bench for uart_rx_fifo_feeder at 16 clocks per bit.
// Frames are bit-banged on rx; a monitor tallies the output pulses.
module tb_uart_rx_fifo_feeder;
   localparam int DW  = 8;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic busy, frame_err, overrun, parity_err;

   uart_rx_fifo_feeder_if #(.DW(DW)) fifo_if ();

   uart_rx_fifo_feeder #(
      .DW(DW),
      .CLK_HZ(16),
      .BAUD(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .fifo(fifo_if.master),
      .busy(busy),
      .frame_err(frame_err),
      .overrun(overrun),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_wen  = 0;
   int n_fe   = 0;
   int n_ov   = 0;
   int n_pe   = 0;
   int n_dbl  = 0;
   logic [DW-1:0] got[$];
   logic wen_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0, pe_p = 1'b0;

   always @(negedge clk) begin
      if (fifo_if.wen) begin
         n_wen++;
         got.push_back(fifo_if.dout);
      end
      if (frame_err)  n_fe++;
      if (overrun)    n_ov++;
      if (parity_err) n_pe++;
      if ((fifo_if.wen && wen_p) || (frame_err && fe_p) ||
          (overrun && ov_p) || (parity_err && pe_p))
         n_dbl++;
      wen_p = fifo_if.wen;
      fe_p  = frame_err;
      ov_p  = overrun;
      pe_p  = parity_err;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      send_bit(1'b0, CPB);
      for (int i = 0; i < DW; i++) send_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
      send_bit(^d, CPB);
`endif
      send_bit(stop_v, CPB);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_odd(input logic [7:0] d);
      send_bit(1'b0, CPB);
      for (int i = 0; i < DW; i++) send_bit(d[i], CPB);
      send_bit(~(^d), CPB);
      send_bit(1'b1, CPB);
   endtask
`endif

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      fifo_if.wfull = 1'b0;
      idle(3);
      rst = 1'b0;
      check("rst_dout", 32'(fifo_if.dout), 32'h0);
      check("rst_wen", 32'(fifo_if.wen), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_fe", 32'(frame_err), 32'h0);
      check("rst_ov", 32'(overrun), 32'h0);
      check("rst_pe", 32'(parity_err), 32'h0);

      // 1: plain byte
      send_frame(8'hA5, 1'b1);
      idle(20);
      check("t1_wen_cnt", 32'(n_wen), 32'd1);
      check("t1_dout", 32'(fifo_if.dout), 32'hA5);
      check("t1_busy", 32'(busy), 32'h0);
      check("t1_fe", 32'(n_fe), 32'd0);
      check("t1_ov", 32'(n_ov), 32'd0);

      // 2: 3-clock glitch
      rx = 1'b0;
      idle(3);
      check("t2_busy_start", 32'(busy), 32'h1);
      rx = 1'b1;
      idle(30);
      check("t2_busy_end", 32'(busy), 32'h0);
      check("t2_wen_cnt", 32'(n_wen), 32'd1);
      check("t2_fe", 32'(n_fe), 32'd0);
      check("t2_ov", 32'(n_ov), 32'd0);

      // 3: stop bit low, line held low 40 clocks
      send_frame(8'h3C, 1'b0);
      send_bit(1'b0, 24);
      check("t3_fe", 32'(n_fe), 32'd1);
      check("t3_wen_cnt", 32'(n_wen), 32'd1);
      check("t3_busy_wait", 32'(busy), 32'h1);
      rx = 1'b1;
      idle(20);
      check("t3_busy_idle", 32'(busy), 32'h0);
      check("t3_fe_once", 32'(n_fe), 32'd1);
      send_frame(8'h11, 1'b1);
      idle(20);
      check("t3_wen_cnt2", 32'(n_wen), 32'd2);
      check("t3_dout", 32'(fifo_if.dout), 32'h11);

      // 4: FIFO full
      fifo_if.wfull = 1'b1;
      send_frame(8'h3C, 1'b1);
      idle(20);
      fifo_if.wfull = 1'b0;
      check("t4_ov", 32'(n_ov), 32'd1);
      check("t4_wen_cnt", 32'(n_wen), 32'd2);
      check("t4_dout", 32'(fifo_if.dout), 32'h11);

      // 5: back-to-back frames
      send_frame(8'h01, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check("t5_wen_cnt", 32'(n_wen), 32'd4);
      check("t5_first", 32'(got[2]), 32'h01);
      check("t5_second", 32'(got[3]), 32'hFF);
      check("t5_dout", 32'(fifo_if.dout), 32'hFF);

      // 6: reset mid-DATA of 0x77
      send_bit(1'b0, CPB);
      send_bit(1'b1, CPB);
      send_bit(1'b1, CPB);
      send_bit(1'b1, CPB);
      rst = 1'b1;
      rx = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(20);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_dout_rst", 32'(fifo_if.dout), 32'h0);
      check("t6_wen_cnt", 32'(n_wen), 32'd4);
      check("t6_fe", 32'(n_fe), 32'd1);
      check("t6_ov", 32'(n_ov), 32'd1);
      send_frame(8'h5A, 1'b1);
      idle(20);
      check("t6_wen_cnt2", 32'(n_wen), 32'd5);
      check("t6_dout", 32'(fifo_if.dout), 32'h5A);

`ifdef UART_RX_PARITY_EN
      send_odd(8'h5A);
      idle(20);
      check("t6_pe", 32'(n_pe), 32'd1);
      check("t6_pe_wen", 32'(n_wen), 32'd5);
`else
      check("pe_never", 32'(n_pe), 32'd0);
`endif
      check("no_double", 32'(n_dbl), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo_feeder.md
Name: uart_rx_fifo_feeder

Overview:
- Upstream producer for the board's synchronous FIFO: receives 8N1 (optionally 8E1) serial frames on a board pin.
- Presents each good byte on din with a single-cycle wen pulse.
- Honours wfull: drops the byte and flags overrun rather than stalling.
- Same clock domain as the FIFO; drives its din/wen ports directly.

Parameters:
- DW, 8, data bits per frame; also the width of dout.
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (derived, localparam), clocks per bit; must be >= 4.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- wfull  input  1  FIFO full flag; sampled in the cycle the byte is delivered.
- dout  output  DW  received byte; connects to FIFO din.
- wen  output  1  one-cycle write strobe; connects to FIFO wen.
- busy  output  1  high while a frame is in progress (any state except IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because wfull=1.
- parity_err  output  1  one-cycle pulse: parity mismatch; constant 0 when the option is off.

Behaviour:
- Interface rule: one clock (clk); reset (rst) is synchronous and active-high.
- Synchroniser:
  - rx passes through two flops to give rx_s.
  - Both flops reset to 1.
  - All decisions use rx_s only.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Cleared on every state entry; counts 0..CLKS_PER_BIT-1.
- Bit counter:
  - Width $clog2(DW)+1.
  - Counts received data bits, LSB first, shifted into a DW-bit shift register.
- FSM states: IDLE, START, DATA, PARITY (present only with the option), STOP, WAIT_HIGH.
- IDLE: rx_s==0 -> START.
- START:
  - At count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - 0 -> DATA with count cleared.
  - 1 -> IDLE (glitch rejected; no flags).
- DATA:
  - At count CLKS_PER_BIT-1, sample rx_s into shift register bit (bit counter), LSB first.
  - After DW samples -> STOP (or PARITY if enabled).
- STOP: at count CLKS_PER_BIT-1, sample rx_s.
  - 1 and no parity error and wfull==0: next cycle dout<=byte, wen=1 for exactly one cycle; -> IDLE.
  - 1 and no parity error and wfull==1: overrun=1 for one cycle; dout unchanged; wen stays 0; -> IDLE.
  - 0: frame_err=1 for one cycle; no write; -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then -> IDLE. A held-low break line never produces repeated frames.
- Latency: wen rises 1 cycle after the mid-stop-bit sample. That is about (1.5 + DW) × CLKS_PER_BIT + 3 clocks after the rx falling edge, including synchroniser delay.
- Output timing: dout is registered and holds its last delivered value between writes. wen, frame_err, overrun and parity_err are registered pulses, never high for two consecutive cycles.
- Back-to-back frames: a start bit immediately following a stop bit is accepted. IDLE is re-entered at mid-stop-bit, leaving half a bit of margin.
- Reset values:
  - State=IDLE; counters=0; shift register=0.
  - dout=0; wen=0; busy=0; frame_err=0; overrun=0; parity_err=0.
  - Synchroniser flops=1.
- Reset mid-frame: the partial byte is discarded; no pulse of any kind is emitted for it.
- wfull is examined only in the delivery cycle. The block never writes while wfull=1, so the FIFO's full guard is never relied upon.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state follows DATA and samples one even-parity bit at mid-bit.
  - In STOP, a mismatch with stop==1 gives parity_err=1 for one cycle, no write, -> IDLE.
  - Stop==0 still gives frame_err, and frame_err takes precedence.
- Undefined:
  - No PARITY state; frame is 8N1.
  - parity_err tied to 0.

Test Plan (CLK_HZ=16, BAUD=1, i.e. CLKS_PER_BIT=16):
1. Send 0xA5 (8N1) with wfull=0 -> exactly one wen pulse, dout=0xA5, busy low afterwards, no error pulses.
2. Drive rx low for 3 clocks, then high -> FSM returns to IDLE from START; wen, frame_err and overrun all stay 0.
3. Send 0x3C with the stop bit forced low, holding rx low for 40 clocks -> one frame_err pulse; no wen; no second frame until rx returns high; then 0x11 is received correctly.
4. Hold wfull=1 while sending 0x3C -> one overrun pulse; wen stays 0; dout keeps its previous value.
5. Send 0x01 then 0xFF back-to-back with zero idle gap -> two wen pulses, with dout=0x01 then 0xFF.
6. Assert rst for 1 cycle mid-DATA of 0x77, then send 0x5A -> no output for 0x77; one wen with dout=0x5A. With UART_RX_PARITY_EN, send 0x5A with odd parity -> parity_err pulse and no wen.
